// File: rtl/cu_sequencer.sv
// Multicycle control-unit sequencer: holds the state register fed by next_state,
// decodes the control word, stalls on memory waits, recovers from illegal states and counts retires.
module cu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ns,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic             bad_state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADDR   = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_RCOMPLETE = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;

  // Memory handshake: MemRead/MemWrite act as the request and stay asserted while
  // the state holds; mem_ready=1 in states 0/3/5 marks the cycle the access completes.
  logic       stall;
  logic       ns_illegal;
  logic       state_illegal;
  logic [3:0] state_d;

  always_comb begin
    stall         = 1'b0;
    ns_illegal    = (ns > S_JUMP);
    state_illegal = (state > S_JUMP);
    state_d       = ns;
    if ((state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready) begin
      stall   = 1'b1;
      state_d = state;
    end else if (ns_illegal || state_illegal) begin
      state_d = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      bad_state <= 1'b0;
    end else begin
      state <= state_d;
      if (!stall && ns_illegal)
        bad_state <= 1'b1;
    end
  end

  // Raw decode of the registered state; write strobes are masked by reset below.
  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic mem_read_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic retire_raw;

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    retire_raw        = 1'b0;
    IorD              = 1'b0;
    MemtoReg          = 1'b0;
    RegDst            = 1'b0;
    ALUSrcA           = 1'b0;
    ALUSrcB           = 2'b00;
    ALUOp             = 2'b00;
    PCSource          = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        retire_raw    = mem_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RCOMPLETE: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = 2'b01;
        pc_write_cond_raw = 1'b1;
        PCSource          = 2'b01;
        retire_raw        = 1'b1;
      end
      S_JUMP: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b10;
        retire_raw   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PCWrite     = pc_write_raw      & ~reset;
  assign PCWriteCond = pc_write_cond_raw & ~reset;
  assign MemRead     = mem_read_raw      & ~reset;
  assign MemWrite    = mem_write_raw     & ~reset;
  assign IRWrite     = ir_write_raw      & ~reset;
  assign RegWrite    = reg_write_raw     & ~reset;
  assign retire      = retire_raw        & ~reset;

  always_ff @(posedge clk) begin
    if (reset)
      instr_count <= '0;
    else if (retire)
      instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: directed vector table, hand sequences for reset and wrap,
// and random stimulus checked against a cycle-level reference model.
module tb_cu_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [3:0]       ns;
  logic             mem_ready;
  logic [3:0]       state;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             bad_state;

  cu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ns(ns), .mem_ready(mem_ready), .state(state),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .retire(retire), .instr_count(instr_count), .bad_state(bad_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ctrl_obs;
  assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  int n_pass;
  int n_total;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // reference model
  int m_state;
  int m_count;
  bit m_bad;

  function automatic logic [15:0] model_ctrl(input int s, input bit mr, input bit rst);
    bit pcw, pcwc, iord, mrd, mwr, irw, mtr, rdst, rw, asa;
    int srcb, aop, pcs;
    pcw  = !rst && ((s == 0 && mr) || s == 9);
    pcwc = !rst && (s == 8);
    iord = (s == 3 || s == 5);
    mrd  = !rst && (s == 0 || s == 3);
    mwr  = !rst && (s == 5);
    irw  = !rst && (s == 0 && mr);
    mtr  = (s == 4);
    rdst = (s == 7);
    rw   = !rst && (s == 4 || s == 7);
    asa  = (s == 2 || s == 6 || s == 8);
    srcb = (s == 0) ? 1 : (s == 1) ? 3 : (s == 2) ? 2 : 0;
    aop  = (s == 6) ? 2 : (s == 8) ? 1 : 0;
    pcs  = (s == 8) ? 1 : (s == 9) ? 2 : 0;
    return {pcw, pcwc, iord, mrd, mwr, irw, mtr, rdst, rw, asa, 2'(srcb), 2'(aop), 2'(pcs)};
  endfunction

  function automatic bit model_retire(input int s, input bit mr, input bit rst);
    if (rst) return 1'b0;
    return (s == 4 || s == 7 || s == 8 || s == 9 || (s == 5 && mr));
  endfunction

  // driver tasks
  task automatic drive(input bit r, input int n, input bit mr);
    reset     = r;
    ns        = 4'(n);
    mem_ready = mr;
    exp_q.push_back(model_ctrl(m_state, mr, r));
  endtask

  task automatic sample();
    @(negedge clk);
    check("state", state, m_state);
    check("ctrl", ctrl_obs, exp_q.pop_front());
    check("retire", retire, model_retire(m_state, mem_ready, reset));
    check("instr_count", instr_count, m_count);
    check("bad_state", bad_state, m_bad);
  endtask

  task automatic advance();
    bit ret;
    int n;
    @(posedge clk);
    ret = model_retire(m_state, mem_ready, reset);
    n   = int'(ns);
    if (reset) begin
      m_state = 0; m_count = 0; m_bad = 0;
    end else begin
      if (ret) m_count = (m_count + 1) % (1 << CNT_W);
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) m_state = m_state;
      else if (n >= 10) begin m_state = 0; m_bad = 1; end
      else m_state = n;
    end
    #1;
  endtask

  task automatic step(input bit r, input int n, input bit mr);
    drive(r, n, mr);
    sample();
    advance();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] ns;
    logic       mr;
    logic [3:0] st;
    logic       ret;
    logic [3:0] cnt;
    logic       bad;
  } vec_t;
  vec_t tab[$];

  task automatic add(input int r, input int n, input int mr, input int st, input int ret,
                     input int cnt, input int bad);
    vec_t v;
    v.rst = 1'(r); v.ns = 4'(n); v.mr = 1'(mr); v.st = 4'(st);
    v.ret = 1'(ret); v.cnt = 4'(cnt); v.bad = 1'(bad);
    tab.push_back(v);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; ns = 4'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_state = 0; m_count = 0; m_bad = 0;
    step(1, 0, 1);

    //   rst ns mr | state retire count bad
    add(0, 1, 1,  0, 0, 0, 0);  // lw
    add(0, 2, 1,  1, 0, 0, 0);
    add(0, 3, 1,  2, 0, 0, 0);
    add(0, 4, 1,  3, 0, 0, 0);
    add(0, 0, 1,  4, 1, 0, 0);
    add(0, 1, 1,  0, 0, 1, 0);  // sw with 3 stall cycles
    add(0, 2, 1,  1, 0, 1, 0);
    add(0, 5, 1,  2, 0, 1, 0);
    add(0, 0, 0,  5, 0, 1, 0);
    add(0, 0, 0,  5, 0, 1, 0);
    add(0, 0, 0,  5, 0, 1, 0);
    add(0, 0, 1,  5, 1, 1, 0);
    add(0, 1, 0,  0, 0, 2, 0);  // fetch stall, then beq
    add(0, 1, 0,  0, 0, 2, 0);
    add(0, 1, 1,  0, 0, 2, 0);
    add(0, 8, 1,  1, 0, 2, 0);
    add(0, 0, 1,  8, 1, 2, 0);
    add(0, 1, 1,  0, 0, 3, 0);  // j
    add(0, 9, 1,  1, 0, 3, 0);
    add(0, 0, 1,  9, 1, 3, 0);
    add(0, 1, 1,  0, 0, 4, 0);  // illegal ns from decode
    add(0, 12, 1, 1, 0, 4, 0);
    add(0, 1, 1,  0, 0, 4, 1);  // R-type
    add(0, 6, 1,  1, 0, 4, 1);
    add(0, 7, 1,  6, 0, 4, 1);
    add(0, 0, 1,  7, 1, 4, 1);
    add(0, 1, 1,  0, 0, 5, 1);  // j
    add(0, 9, 1,  1, 0, 5, 1);
    add(0, 0, 1,  9, 1, 5, 1);
    add(1, 1, 1,  0, 0, 6, 1);  // reset clears sticky flag and count
    add(0, 1, 1,  0, 0, 0, 0);

    foreach (tab[i]) begin
      drive(tab[i].rst, int'(tab[i].ns), tab[i].mr);
      sample();
      check("tab_state", state, tab[i].st);
      check("tab_retire", retire, tab[i].ret);
      check("tab_count", instr_count, tab[i].cnt);
      check("tab_bad", bad_state, tab[i].bad);
      advance();
    end

    // reset in state 6
    step(0, 6, 1);
    drive(1, 7, 1);
    sample();
    check("rst6_writes", {PCWrite, PCWriteCond, IRWrite, MemWrite, MemRead, RegWrite}, 6'b0);
    advance();
    check("rst6_state", state, 0);
    check("rst6_count", instr_count, 0);

    // reset during a sw stall
    step(0, 1, 1); step(0, 2, 1); step(0, 5, 1); step(0, 0, 0);
    drive(1, 0, 0);
    sample();
    check("rst5_memwrite", MemWrite, 0);
    check("rst5_retire", retire, 0);
    advance();
    check("rst5_state", state, 0);

    // counter wrap with 16 jumps
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 1); step(0, 9, 1); step(0, 0, 1);
      if (k == 14) check("wrap_15", instr_count, 15);
    end
    check("wrap_0", instr_count, 0);

    // simultaneous retire and reset
    step(0, 1, 1); step(0, 9, 1);
    step(1, 0, 1);
    check("retire_rst_count", instr_count, 0);

    // random stimulus
    for (int c = 0; c < 3000; c++) begin
      bit r, mr;
      int n;
      r  = ($urandom_range(0, 49) == 0);
      mr = ($urandom_range(0, 9) < 7);
      n  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      step(r, n, mr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
# cu_sequencer

Multicycle control-unit sequencer: the consumer of the `next_state` transition function. It holds the 4-bit state register and feeds `state` back to `next_state`. It registers the returned `ns` and decodes the current state into the datapath control word. It also adds memory-wait stalling, illegal-state recovery and an instruction-retire counter, so together with `next_state` it forms the complete control unit for the multicycle datapath.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `ns` in 4 — next state from `next_state`
- `mem_ready` in 1 — memory completes the current access this cycle
- `state` out 4 — current state register, to `next_state.state`
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1 each — control strobes/selects
- `ALUSrcB` out 2, `ALUOp` out 2, `PCSource` out 2 — mux selects
- `retire` out 1 — last cycle of an instruction
- `instr_count` out CNT_W — retired instructions, wraps
- `bad_state` out 1 — sticky, `ns` was ever >= 10

## Operation
- States: 0 fetch, 1 decode, 2 memaddr, 3 memread, 4 mem writeback, 5 memwrite, 6 execute, 7 R completion, 8 branch, 9 jump.
- Unlisted signals are 0 in every state.
- **State 0:** MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready.
- **State 1:** ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- **State 2:** ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- **State 3:** MemRead=1, IorD=1.
- **State 4:** RegWrite=1, MemtoReg=1, RegDst=0.
- **State 5:** MemWrite=1, IorD=1.
- **State 6:** ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- **State 7:** RegWrite=1, RegDst=1, MemtoReg=0.
- **State 8:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- **State 9:** PCWrite=1, PCSource=10.
- **State register update, first matching rule wins:**
  - reset → 0
  - state ∈ {0,3,5} and mem_ready=0 → hold
  - ns ≥ 10 → 0, and set bad_state
  - otherwise → ns
- `state` ≥ 10 cannot occur. If it does (X-clear only), decode all strobes to 0 and load 0 next edge.
- `retire`:
  - 1 in states 4, 7, 8, 9.
  - 1 in state 5 only when mem_ready=1.
  - 0 in every other state.
- On each clock edge where `retire`=1, `instr_count` increments by 1 modulo 2^CNT_W.
- `bad_state` clears only on reset.

## Timing
- All control outputs and `retire` are combinational from the registered `state` plus `mem_ready`. They are valid in the same cycle as `state`.
- `ns` is sampled on the rising edge, so a state transition takes 1 cycle.
- Without stalls the total cycle counts are: lw 5, sw 4, R 4, beq 3, j 3.
- Each stall cycle adds 1 cycle.
- `mem_ready` is required only in states 0, 3, 5 and is ignored elsewhere.
- While `reset`=1, these are forced to 0 regardless of state: PCWrite, PCWriteCond, IRWrite, MemWrite, MemRead, RegWrite, retire.
- **Register values after the reset edge:** state=0, instr_count=0, bad_state=0.
- **Output values after the reset edge:** the remaining selects show the state-0 decode.
- Reset mid-instruction (any state, including a stall) drops to fetch on the next edge. No partial retire is counted.
- In state 5, a stall holds MemWrite high on consecutive cycles. The write commits only on the mem_ready cycle; the memory is responsible for this.
- Simultaneous `retire` and `reset` on the same edge: reset wins and the count becomes 0.
- `instr_count` at 2^CNT_W−1 with retire=1 → 0 on that edge. No flag is raised.

## Test plan
- Reset, then drive `ns` with the lw sequence 1,2,3,4,0, mem_ready=1:
  - states are 0→1→2→3→4→0
  - IRWrite=1 in cycle 0; RegWrite=MemtoReg=1 in state 4
  - instr_count=1
- sw with mem_ready low for 3 cycles in state 5:
  - state stays 5 for 4 cycles with MemWrite=1
  - retire=1 only on the 4th cycle; instr_count increments by 1
- Fetch stall: state 0 with mem_ready=0 for 2 cycles:
  - state holds 0; PCWrite=IRWrite=0
  - on the third cycle mem_ready=1 → PCWrite=IRWrite=1, then state=ns=1
- beq and j paths:
  - state 8 → PCWriteCond=1, PCSource=01, ALUOp=01
  - state 9 → PCWrite=1, PCSource=10
  - each raises retire=1 for 1 cycle
- Illegal ns=4'b1100 from state 1:
  - next state=0; bad_state=1 and stays set through 2 further instructions
  - reset clears it to 0
- CNT_W=4: retire 16 instructions → instr_count wraps 15→0.
- Reset asserted in state 6 → next edge state=0, instr_count=0, all write strobes 0 during reset.
